// File: rtl/prog_fetch_if.sv
// Handshake and instruction bus between the fetch stage and its neighbours
// (start/halt control, instruction ROM, decode and datapath).
interface prog_fetch_if #(
  parameter int PC_W    = 10,
  parameter int INSTR_W = 9,
  parameter int OFF_W   = 6,
  parameter int CNT_W   = 16
);
  logic                start;
  logic [INSTR_W-1:0]  rom_data;
  logic                stall;
  logic                branch_en;
  logic                branch_rel;
  logic [PC_W-1:0]     branch_target;
  logic [OFF_W-1:0]    branch_offset;
  logic                halt_req;
  logic [PC_W-1:0]     rom_addr;
  logic [INSTR_W-1:0]  instr;
  logic                instr_valid;
  logic                halt;
  logic [CNT_W-1:0]    cycle_count;

  // Fetch stage side.
  modport slave (
    input  start, rom_data, stall, branch_en, branch_rel,
           branch_target, branch_offset, halt_req,
    output rom_addr, instr, instr_valid, halt, cycle_count
  );

  // Driver side: ROM, decode, datapath and the launch controller.
  modport master (
    output start, rom_data, stall, branch_en, branch_rel,
           branch_target, branch_offset, halt_req,
    input  rom_addr, instr, instr_valid, halt, cycle_count
  );
endinterface

// File: rtl/prog_fetch.sv
// Program counter / instruction fetch stage: start/halt handshake, PC
// sequencing with stall and absolute/relative branches, RUN-cycle counter.
module prog_fetch #(
  parameter int PC_W    = 10,
  parameter int INSTR_W = 9,
  parameter int OFF_W   = 6,
  parameter int CNT_W   = 16
) (
  input  logic      CLK,
  input  logic      RST_N,
  prog_fetch_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [PC_W-1:0]   pc_q, pc_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              start_q, start_d;
  logic              halt_q, halt_d;
  logic              valid_q, valid_d;

  logic              launch;
  logic [PC_W-1:0]   offset_ext;
  logic [CNT_W-1:0]  cnt_sat_inc;

  // Launch on the falling edge of start as seen at the clock.
  assign launch      = start_q & ~bus.start;
  assign offset_ext  = {{(PC_W-OFF_W){bus.branch_offset[OFF_W-1]}}, bus.branch_offset};
  assign cnt_sat_inc = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves
    // it unassigned; otherwise synthesis would infer a latch.
    state_d = state_q;
    pc_d    = pc_q;
    cnt_d   = cnt_q;
    start_d = bus.start;
    halt_d  = halt_q;
    valid_d = valid_q;

    unique case (state_q)
      IDLE: begin
        pc_d  = '0;
        cnt_d = '0;
        if (launch) begin
          state_d = RUN;
          valid_d = 1'b1;
        end
      end

      RUN: begin
        if (bus.start) begin
          state_d = IDLE;
          pc_d    = '0;
          cnt_d   = '0;
          valid_d = 1'b0;
        end else begin
          cnt_d = cnt_sat_inc;
          if (bus.halt_req) begin
            // PC stays on the halt instruction.
            state_d = HALT;
            halt_d  = 1'b1;
            valid_d = 1'b0;
          end else if (bus.stall) begin
            // A branch presented during a stall is dropped, not deferred.
            pc_d = pc_q;
          end else if (bus.branch_en) begin
            pc_d = bus.branch_rel ? pc_q + offset_ext : bus.branch_target;
          end else begin
            pc_d = pc_q + PC_W'(1);
          end
        end
      end

      HALT: begin
        if (bus.start) begin
          state_d = IDLE;
          pc_d    = '0;
          cnt_d   = '0;
          halt_d  = 1'b0;
        end
      end

      default: begin
        state_d = IDLE;
        pc_d    = '0;
        cnt_d   = '0;
        halt_d  = 1'b0;
        valid_d = 1'b0;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= IDLE;
      pc_q    <= '0;
      cnt_q   <= '0;
      start_q <= 1'b0;
      halt_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
      start_q <= start_d;
      halt_q  <= halt_d;
      valid_q <= valid_d;
    end
  end

  assign bus.rom_addr    = pc_q;
  assign bus.instr       = valid_q ? bus.rom_data : '0;
  assign bus.instr_valid = valid_q;
  assign bus.halt        = halt_q;
  assign bus.cycle_count = cnt_q;

endmodule

// File: tb/tb_prog_fetch.sv
// Directed bench for prog_fetch: a vector table for the main run, then
// hand-written launch/stall/halt/reset sequences and a saturating-counter instance.
module tb_prog_fetch;

  logic clk;
  logic rst_n;

  int checks = 0;
  int errors = 0;

  prog_fetch_if #(.PC_W(10), .INSTR_W(9), .OFF_W(6), .CNT_W(16)) bus ();
  prog_fetch_if #(.PC_W(10), .INSTR_W(9), .OFF_W(6), .CNT_W(4))  sbus ();

  prog_fetch #(.PC_W(10), .INSTR_W(9), .OFF_W(6), .CNT_W(16)) dut (
    .CLK   (clk),
    .RST_N (rst_n),
    .bus   (bus)
  );

  prog_fetch #(.PC_W(10), .INSTR_W(9), .OFF_W(6), .CNT_W(4)) dut_sat (
    .CLK   (clk),
    .RST_N (rst_n),
    .bus   (sbus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        start;
    logic        stall;
    logic        br_en;
    logic        br_rel;
    logic        hreq;
    logic [9:0]  tgt;
    logic [5:0]  off;
    logic [8:0]  rom;
    logic [9:0]  e_addr;
    logic        e_valid;
    logic        e_halt;
    logic [15:0] e_cnt;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.stall         = 1'b0;
    bus.branch_en     = 1'b0;
    bus.branch_rel    = 1'b0;
    bus.branch_target = '0;
    bus.branch_offset = '0;
    bus.halt_req      = 1'b0;
  endtask

  task automatic check_state(input string tag, input logic [9:0] addr, input logic valid,
                             input logic hlt, input logic [15:0] cnt);
    check({tag, " addr"},  32'(bus.rom_addr),    32'(addr));
    check({tag, " valid"}, 32'(bus.instr_valid), 32'(valid));
    check({tag, " halt"},  32'(bus.halt),        32'(hlt));
    check({tag, " cnt"},   32'(bus.cycle_count), 32'(cnt));
    check({tag, " instr"}, 32'(bus.instr),       valid ? 32'(bus.rom_data) : 32'd0);
  endtask

  // Reset, hold start high, drop it: leaves the DUT on its first RUN cycle.
  task automatic reset_and_launch();
    clear_inputs();
    bus.start = 1'b1;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();
  endtask

  function automatic vec_t mk(logic start, logic stall, logic br_en, logic br_rel, logic hreq,
                              logic [9:0] tgt, logic [5:0] off, logic [8:0] rom,
                              logic [9:0] e_addr, logic e_valid, logic e_halt, logic [15:0] e_cnt);
    vec_t v;
    v.start = start; v.stall = stall; v.br_en = br_en; v.br_rel = br_rel; v.hreq = hreq;
    v.tgt = tgt; v.off = off; v.rom = rom;
    v.e_addr = e_addr; v.e_valid = e_valid; v.e_halt = e_halt; v.e_cnt = e_cnt;
    return v;
  endfunction

  initial begin
    //            st stl br rel hq  tgt    off        rom     addr  v  h  cnt
    vecs.push_back(mk(1, 0, 0, 0, 0, 10'd0,   6'd0,      9'h011, 10'd0,    0, 0, 16'd0));
    vecs.push_back(mk(1, 0, 0, 0, 0, 10'd0,   6'd0,      9'h022, 10'd0,    0, 0, 16'd0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 10'd0,   6'd0,      9'h033, 10'd0,    1, 0, 16'd0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 10'd0,   6'd0,      9'h044, 10'd1,    1, 0, 16'd1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 10'd0,   6'd0,      9'h055, 10'd2,    1, 0, 16'd2));
    vecs.push_back(mk(0, 0, 0, 0, 0, 10'd0,   6'd0,      9'h066, 10'd3,    1, 0, 16'd3));
    vecs.push_back(mk(0, 0, 0, 0, 0, 10'd0,   6'd0,      9'h077, 10'd4,    1, 0, 16'd4));
    vecs.push_back(mk(0, 0, 0, 0, 0, 10'd0,   6'd0,      9'h088, 10'd5,    1, 0, 16'd5));
    vecs.push_back(mk(0, 0, 1, 0, 0, 10'd200, 6'd0,      9'h099, 10'd200,  1, 0, 16'd6));
    vecs.push_back(mk(0, 0, 1, 1, 0, 10'd0,   6'b111110, 9'h0AA, 10'd198,  1, 0, 16'd7));
    vecs.push_back(mk(0, 1, 1, 0, 0, 10'd50,  6'd0,      9'h0BB, 10'd198,  1, 0, 16'd8));
    vecs.push_back(mk(0, 1, 1, 0, 0, 10'd50,  6'd0,      9'h0CC, 10'd198,  1, 0, 16'd9));
    vecs.push_back(mk(0, 0, 0, 0, 0, 10'd50,  6'd0,      9'h0DD, 10'd199,  1, 0, 16'd10));
    vecs.push_back(mk(0, 0, 1, 0, 0, 10'd1023,6'd0,      9'h0EE, 10'd1023, 1, 0, 16'd11));
    vecs.push_back(mk(0, 0, 0, 0, 0, 10'd0,   6'd0,      9'h0FF, 10'd0,    1, 0, 16'd12));
    vecs.push_back(mk(0, 0, 1, 1, 0, 10'd0,   6'b100000, 9'h101, 10'd992,  1, 0, 16'd13));
    vecs.push_back(mk(0, 0, 1, 1, 0, 10'd0,   6'b011111, 9'h102, 10'd1023, 1, 0, 16'd14));
    vecs.push_back(mk(0, 0, 1, 1, 0, 10'd0,   6'b000001, 9'h103, 10'd0,    1, 0, 16'd15));
    vecs.push_back(mk(0, 1, 1, 0, 1, 10'd77,  6'd0,      9'h104, 10'd0,    0, 1, 16'd16));
    vecs.push_back(mk(0, 1, 1, 0, 1, 10'd77,  6'd0,      9'h105, 10'd0,    0, 1, 16'd16));
    vecs.push_back(mk(1, 0, 0, 0, 0, 10'd0,   6'd0,      9'h106, 10'd0,    0, 0, 16'd0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 10'd0,   6'd0,      9'h107, 10'd0,    1, 0, 16'd0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 10'd0,   6'd0,      9'h108, 10'd1,    1, 0, 16'd1));
    vecs.push_back(mk(1, 0, 0, 0, 0, 10'd0,   6'd0,      9'h109, 10'd0,    0, 0, 16'd0));
    vecs.push_back(mk(1, 1, 1, 0, 1, 10'd9,   6'd0,      9'h10A, 10'd0,    0, 0, 16'd0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 10'd0,   6'd0,      9'h10B, 10'd0,    1, 0, 16'd0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 10'd0,   6'd0,      9'h10C, 10'd1,    1, 0, 16'd1));

    rst_n = 1'b0;
    clear_inputs();
    bus.start    = 1'b1;
    bus.rom_data = 9'h1A5;
    sbus.start = 1'b0; sbus.rom_data = '0; sbus.stall = 1'b0; sbus.branch_en = 1'b0;
    sbus.branch_rel = 1'b0; sbus.branch_target = '0; sbus.branch_offset = '0; sbus.halt_req = 1'b0;

    #3;
    check_state("reset", 10'd0, 1'b0, 1'b0, 16'd0);
    tick();
    tick();
    check_state("reset held", 10'd0, 1'b0, 1'b0, 16'd0);
    #2 rst_n = 1'b1;

    foreach (vecs[i]) begin
      bus.start         = vecs[i].start;
      bus.stall         = vecs[i].stall;
      bus.branch_en     = vecs[i].br_en;
      bus.branch_rel    = vecs[i].br_rel;
      bus.halt_req      = vecs[i].hreq;
      bus.branch_target = vecs[i].tgt;
      bus.branch_offset = vecs[i].off;
      bus.rom_data      = vecs[i].rom;
      tick();
      check_state($sformatf("v%0d", i), vecs[i].e_addr, vecs[i].e_valid,
                  vecs[i].e_halt, vecs[i].e_cnt);
    end

    // Stall wins over branch; dropped branch is not replayed.
    bus.rom_data = 9'h155;
    reset_and_launch();
    check_state("launch", 10'd0, 1'b1, 1'b0, 16'd0);
    for (int i = 0; i < 7; i++) tick();
    check_state("pre-stall", 10'd7, 1'b1, 1'b0, 16'd7);
    bus.stall = 1'b1; bus.branch_en = 1'b1; bus.branch_target = 10'd50;
    tick();
    check_state("stall1", 10'd7, 1'b1, 1'b0, 16'd8);
    tick();
    check_state("stall2", 10'd7, 1'b1, 1'b0, 16'd9);
    clear_inputs();
    tick();
    check_state("post-stall", 10'd8, 1'b1, 1'b0, 16'd10);

    // Halt wins over a simultaneous branch, then holds until start.
    reset_and_launch();
    for (int i = 0; i < 12; i++) tick();
    check_state("pre-halt", 10'd12, 1'b1, 1'b0, 16'd12);
    bus.halt_req = 1'b1; bus.branch_en = 1'b1; bus.branch_target = 10'd300;
    tick();
    check_state("halt", 10'd12, 1'b0, 1'b1, 16'd13);
    bus.halt_req = 1'b0;
    for (int i = 0; i < 20; i++) begin
      bus.stall     = i[0];
      bus.branch_en = i[1];
      tick();
      check_state($sformatf("halt hold%0d", i), 10'd12, 1'b0, 1'b1, 16'd13);
    end
    clear_inputs();
    bus.start = 1'b1;
    tick();
    check_state("halt exit", 10'd0, 1'b0, 1'b0, 16'd0);

    // Asynchronous reset mid-run; no relaunch without a fresh start pulse.
    reset_and_launch();
    for (int i = 0; i < 30; i++) tick();
    check_state("pre-rst", 10'd30, 1'b1, 1'b0, 16'd30);
    #2 rst_n = 1'b0;
    #1;
    check_state("async rst", 10'd0, 1'b0, 1'b0, 16'd0);
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    check_state("no relaunch", 10'd0, 1'b0, 1'b0, 16'd0);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();
    check_state("relaunch", 10'd0, 1'b1, 1'b0, 16'd0);
    tick();
    check_state("relaunch+1", 10'd1, 1'b1, 1'b0, 16'd1);

    // 4-bit counter saturates at 15.
    sbus.start = 1'b1;
    tick();
    sbus.start = 1'b0;
    tick();
    check("sat launch valid", 32'(sbus.instr_valid), 32'd1);
    check("sat launch cnt", 32'(sbus.cycle_count), 32'd0);
    for (int i = 0; i < 14; i++) tick();
    check("sat cnt14", 32'(sbus.cycle_count), 32'd14);
    tick();
    check("sat cnt15", 32'(sbus.cycle_count), 32'd15);
    for (int i = 0; i < 5; i++) tick();
    check("sat cnt stuck", 32'(sbus.cycle_count), 32'd15);
    check("sat pc", 32'(sbus.rom_addr), 32'd20);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/prog_fetch.md
Name: prog_fetch

Overview:
- Program-counter and instruction-fetch stage that sits directly upstream of the datapath (register file, ALU, data memory) inside the processor top level.
- Owns the start/halt handshake: it holds the core idle while `start` is high, launches execution when `start` falls, and sequences the PC.
- It addresses the instruction ROM, forwards the fetched word to decode, applies branches and stalls, and raises the `halt` done flag that the bench waits on.

Parameters:
- PC_W, 10, program counter / instruction ROM address width.
- INSTR_W, 9, instruction word width.
- OFF_W, 6, signed relative-branch offset width.
- CNT_W, 16, executed-cycle counter width.

Ports:
- CLK  input  1  system clock; all state updates on rising edge.
- RST_N  input  1  asynchronous, active-low reset.
- start  input  1  high = hold core idle and clear PC; falling edge launches program.
- rom_data  input  INSTR_W  instruction word from combinational instruction ROM at rom_addr.
- stall  input  1  from datapath; hold PC this cycle.
- branch_en  input  1  from decode; take branch this cycle.
- branch_rel  input  1  1 = relative branch, 0 = absolute branch.
- branch_target  input  PC_W  absolute destination.
- branch_offset  input  OFF_W  signed two's-complement relative offset.
- halt_req  input  1  from decode; current instruction is halt.
- rom_addr  output  PC_W  current PC, drives ROM address.
- instr  output  INSTR_W  fetched instruction to decode; equals rom_data when instr_valid, else 0.
- instr_valid  output  1  high only in RUN.
- halt  output  1  done flag.
- cycle_count  output  CNT_W  number of RUN cycles since launch.

Behaviour:
- **Reset** (RST_N low, asynchronous):
  - state = IDLE; PC = 0; start_q = 0; cycle_count = 0.
  - Outputs: halt = 0, instr_valid = 0, instr = 0.
  - Effect is immediate, mid-operation included.
- start_q is a registered copy of start. Launch condition: start_q = 1 and start = 0 (falling edge seen at the clock).
- **States:**
  - IDLE: PC held at 0; instr_valid = 0; halt = 0.
    - Launch → RUN.
    - Sitting in IDLE with start low and no prior high does not launch.
  - RUN: instr_valid = 1. Per cycle, priority highest first:
    1. start = 1 → IDLE, PC = 0, cycle_count = 0.
    2. halt_req = 1 → HALT; PC unchanged.
    3. stall = 1 → PC unchanged.
    4. branch_en = 1, branch_rel = 0 → PC = branch_target.
    5. branch_en = 1, branch_rel = 1 → PC = PC + sign_extend(branch_offset), modulo 2^PC_W.
    6. Otherwise → PC = PC + 1, modulo 2^PC_W.
    - cycle_count increments every RUN cycle, including stall and halt_req cycles. It saturates at all-ones and does not wrap.
  - HALT: halt = 1 (registered, asserted first cycle after halt_req sampled); instr_valid = 0; PC and cycle_count frozen.
    - Only start = 1 leaves HALT → IDLE, PC = 0, cycle_count = 0, halt = 0 next cycle.
- **Latency:**
  - PC update is one cycle; rom_addr = PC with no additional delay.
  - instr is combinational from rom_data, gated by instr_valid.
- **Inputs ignored outside RUN:** branch_en, stall and halt_req have no effect in IDLE and HALT.
- **Simultaneous events:**
  - halt_req with branch_en or stall: halt wins and the PC is frozen at the halt instruction.
  - stall with branch_en: the branch is dropped, not deferred. Decode must re-present it.
- **Wrap-around:**
  - PC = 2^PC_W − 1 increments to 0.
  - A relative branch past either end wraps.
  - Negative offsets step backward, e.g. offset 6'b111110 = −2.

Test Plan:
- Reset and launch: RST_N low, start = 1 for 2 cycles, then start = 0 → rom_addr = 0, instr_valid = 1 on the first RUN cycle; rom_addr = 1, 2, 3 on the following cycles; halt = 0.
- Branches: at PC = 5, branch_en = 1, branch_rel = 0, target = 10'd200 → next PC = 200. At PC = 200, branch_rel = 1, offset = −2 → PC = 198. At PC = 1023 with no branch → PC = 0.
- Stall priority: at PC = 7, stall = 1 and branch_en = 1 (target 50) for 2 cycles → PC stays 7 and cycle_count still increments by 2; after the stall drops with no branch → PC = 8.
- Halt: halt_req at PC = 12, cycle_count = 12, with branch_en = 1 simultaneously → next cycle halt = 1, instr_valid = 0, PC = 12, cycle_count = 13, held for 20 cycles. Then start = 1 → halt = 0, PC = 0, cycle_count = 0.
- Mid-run reset: RST_N pulled low asynchronously between clock edges at PC = 30 → PC = 0, state IDLE, outputs zero immediately. Program does not relaunch until start goes high then low.
- Counter saturation: CNT_W overridden to 4; run 20 cycles with no halt → cycle_count sticks at 15.
